zapper_flash_ctl: RTL and testbench

//  Light-gun shot sequencer in the top-level input section, between the gun

---
 rtl/zapper_flash_ctl.sv | 96 +++++++++
 tb/tb_zapper_flash_ctl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zapper_flash_ctl.sv
// zapper_flash_ctl: light-gun shot sequencer (trigger debounce, black/target flash frames, hit/miss verdict)
module zapper_flash_ctl #(
  parameter int DEBOUNCE_CYCLES     = 65000,
  parameter int SAMPLE_DELAY_CYCLES = 2000,
  parameter int FLASH_FRAMES        = 1,
  parameter int COOLDOWN_FRAMES     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic new_frame,
  input  logic gun_is_connected,
  input  logic gun_trigger,
  input  logic gun_photodetector,
  input  logic duck_show,
  output logic flash_black,
  output logic flash_target,
  output logic shot_fired,
  output logic hit,
  output logic miss,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, BLACK, TARGET, RESULT, COOLDOWN} state_t;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SAMPLE_DELAY_CYCLES + 1);
  localparam int FW = $clog2((FLASH_FRAMES > COOLDOWN_FRAMES ? FLASH_FRAMES : COOLDOWN_FRAMES) + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] DLY_MAX = SW'(SAMPLE_DELAY_CYCLES);
  localparam logic [FW-1:0] FL_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [FW-1:0] CD_LAST = FW'(COOLDOWN_FRAMES == 0 ? 0 : COOLDOWN_FRAMES - 1);
  state_t state, state_n;
  logic [1:0] trig_s, photo_s;
  logic [DW-1:0] deb_cnt;
  logic [SW-1:0] dly;
  logic [FW-1:0] frame_cnt;
  logic armed, seen, dark_fail, tgt_valid;
  logic accept, sample, flash_done, cd_done, abort, verdict;
  assign accept = trig_s[1] && armed && deb_cnt == DEB_LAST;
  assign sample = photo_s[1] && dly == DLY_MAX;
  assign flash_done = new_frame && frame_cnt == FL_LAST;
  assign cd_done = new_frame && frame_cnt == CD_LAST;
  assign abort = !gun_is_connected;
  assign verdict = seen && tgt_valid && !dark_fail;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = accept && gun_is_connected ? WAIT_FRAME : IDLE;
      WAIT_FRAME: state_n = abort ? IDLE : new_frame ? BLACK : WAIT_FRAME;
      BLACK:      state_n = abort ? IDLE : flash_done ? TARGET : BLACK;
      TARGET:     state_n = abort ? IDLE : flash_done ? RESULT : TARGET;
      RESULT:     state_n = COOLDOWN_FRAMES == 0 ? IDLE : COOLDOWN;
      COOLDOWN:   state_n = abort || cd_done ? IDLE : COOLDOWN;
      default:    state_n = IDLE;
    endcase
  end
  always_comb begin
    flash_black = state == BLACK;
    flash_target = state == TARGET && tgt_valid;
    hit = state == RESULT && verdict;
    miss = state == RESULT && !verdict;
    busy = state != IDLE;
  end
  // Debounced edge fires once per pull; a dropped edge outside IDLE still disarms until release.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      trig_s <= '0;
      photo_s <= '0;
      deb_cnt <= '0;
      armed <= 1'b0;
      dly <= '0;
      frame_cnt <= '0;
      shot_fired <= 1'b0;
      seen <= 1'b0;
      dark_fail <= 1'b0;
      tgt_valid <= 1'b0;
    end else begin
      trig_s <= {trig_s[0], gun_trigger};
      photo_s <= {photo_s[0], gun_photodetector};
      deb_cnt <= !trig_s[1] ? '0 : deb_cnt == DEB_LAST ? deb_cnt : deb_cnt + DW'(1);
      armed <= trig_s[1] ? armed && !accept : 1'b1;
      dly <= new_frame ? '0 : dly == DLY_MAX ? dly : dly + SW'(1);
      frame_cnt <= state_n != state ? '0 : new_frame && frame_cnt != '1 ? frame_cnt + FW'(1) : frame_cnt;
      shot_fired <= state == IDLE && state_n == WAIT_FRAME;
      if (state == IDLE) begin
        seen <= 1'b0;
        dark_fail <= 1'b0;
        tgt_valid <= 1'b0;
      end else begin
        dark_fail <= dark_fail || (state == BLACK && sample);
        seen <= seen || (state == TARGET && sample);
        tgt_valid <= state == BLACK && state_n == TARGET ? duck_show : tgt_valid;
      end
    end
endmodule

// File: tb/tb_zapper_flash_ctl.sv
// tb_zapper_flash_ctl: randomized scenarios checked against a frame-timeline model of the shot sequence
module tb_zapper_flash_ctl;
  localparam int DEB = 20, SD = 8, FF = 2, CD = 10, FP = 40, TMAX = 40000, NONE = 1 << 30;
  logic clk = 0, rst = 0, new_frame = 0, gun_is_connected = 1, gun_trigger = 0;
  logic gun_photodetector = 0, duck_show = 0;
  logic flash_black, flash_target, shot_fired, hit, miss, busy;
  int checks = 0, failures = 0, cyc = 0, first_c = 0;
  int s, kf, kb, kt, ke, kd, k0, trig_a, trig_b, trig2_a, trig2_b;
  bit p_duck, p_blk, p_tgt, cheat, p_disc, disc_all, res;
  logic [5:0] tr [0:TMAX-1];

  zapper_flash_ctl #(.DEBOUNCE_CYCLES(DEB), .SAMPLE_DELAY_CYCLES(SD), .FLASH_FRAMES(FF),
                     .COOLDOWN_FRAMES(CD)) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .gun_is_connected(gun_is_connected),
    .gun_trigger(gun_trigger), .gun_photodetector(gun_photodetector), .duck_show(duck_show),
    .flash_black(flash_black), .flash_target(flash_target), .shot_fired(shot_fired),
    .hit(hit), .miss(miss), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #(TMAX * 10);
    $display("FAIL watchdog: simulation time exceeded at cycle %0d", cyc);
    $fatal(1);
  end

  // Expected outputs after edge c, derived from the shot timeline: shot, frame boundaries, end.
  function automatic logic [5:0] exp_at(int c);
    return {c == s, c >= kf && c < kb && c < ke, p_duck && c >= kb && c < kt && c < ke,
            c == kt && kt < ke && res, c == kt && kt < ke && !res, c >= s && c < ke};
  endfunction

  function automatic int wave_bad(int lo, int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++)
      if (tr[c] !== exp_at(c)) begin
        if (n == 0) first_c = c;
        n++;
      end
    return n;
  endfunction

  function automatic int count_bit(int lo, int hi, int b);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += (tr[c][b] === 1'b1) ? 1 : 0;
    return n;
  endfunction

  task automatic step();
    int c = cyc + 1;
    new_frame = (c % FP == 0);
    gun_photodetector = cheat || (p_blk && c >= kf + SD + 2 && c <= kf + FP - 3) ||
                        (p_tgt && c >= kb + SD + 2 && c <= kb + FP - 3);
    duck_show = (c == kb) ? p_duck : 1'($urandom);
    gun_is_connected = !disc_all && !(p_disc && c >= kd && c < kd + 10);
    gun_trigger = (c >= trig_a && c < trig_b) || (c >= trig2_a && c < trig2_b);
    @(posedge clk);
    cyc = c;
    #1;
    if (cyc < TMAX) tr[cyc] = {shot_fired, flash_black, flash_target, hit, miss, busy};
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic run_to(int c);
    while (cyc < c) step();
  endtask

  task automatic clear_plan();
    s = NONE; kf = NONE; kb = NONE; kt = NONE; ke = NONE; kd = NONE;
    trig_a = 0; trig_b = 0; trig2_a = 0; trig2_b = 0;
    p_duck = 0; p_blk = 0; p_tgt = 0; cheat = 0; p_disc = 0; res = 0;
  endtask

  task automatic plan_shot(bit duck, bit blk, bit tgt, bit ch, bit disc, bit cdp, int hold);
    clear_plan();
    k0 = cyc + 1;
    trig_a = k0;
    trig_b = k0 + hold;
    s = k0 + DEB + 1;
    kf = (s / FP + 1) * FP;
    kb = kf + FF * FP;
    kt = kb + FF * FP;
    ke = kt + CD * FP;
    p_duck = duck; cheat = ch; p_blk = blk || ch; p_tgt = tgt || ch; p_disc = disc;
    res = duck && p_tgt && !p_blk;
    if (disc) begin
      kd = kf + $urandom_range(1, FF * FP - 1);
      ke = kd;
    end
    if (cdp) begin
      trig2_a = kt + 4 * FP + 5;
      trig2_b = trig2_a + DEB + 10;
    end
  endtask

  task automatic test_reset();
    clear_plan();
    repeat (3) step();
    checks++;
    if ({shot_fired, flash_black, flash_target, hit, miss, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 000000", {shot_fired, flash_black, flash_target, hit, miss, busy});
    end
    rst = 1;
    idle(5);
    checks++;
    if (count_bit(cyc - 4, cyc, 0) !== 0) begin
      failures++;
      $display("FAIL reset_idle_busy: busy cycles %0d want 0", count_bit(cyc - 4, cyc, 0));
    end
  endtask

  task automatic test_reset_mid_target();
    int r;
    idle(7);
    plan_shot(1, 0, 1, 0, 0, 0, DEB);
    run_to(kb + 10);
    checks++;
    if (flash_target !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_target_pre: flash_target=%b busy=%b want 1 1", flash_target, busy);
    end
    rst = 0;
    #1;
    checks++;
    if (flash_target !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_drop: flash_target=%b busy=%b want 0 0", flash_target, busy);
    end
    repeat (3) step();
    rst = 1;
    r = cyc;
    run_to(kt + 2 * FP);
    checks++;
    if (count_bit(r, cyc, 2) + count_bit(r, cyc, 1) + count_bit(r, cyc, 0) + count_bit(r, cyc, 3) !== 0) begin
      failures++;
      $display("FAIL reset_no_result: hit=%0d miss=%0d busy=%0d ftgt=%0d want all 0", count_bit(r, cyc, 2),
               count_bit(r, cyc, 1), count_bit(r, cyc, 0), count_bit(r, cyc, 3));
    end
    clear_plan();
  endtask

  task automatic test_clean_hit();
    int bad;
    idle($urandom_range(5, FP));
    plan_shot(1, 0, 1, 0, 0, 0, DEB);
    run_to(ke + 5);
    bad = wave_bad(k0, ke + 4);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clean_hit_wave: %0d cycles differ, first %0d got %b want %b", bad, first_c, tr[first_c], exp_at(first_c));
    end
    checks++;
    if (count_bit(k0, ke + 4, 2) !== 1 || count_bit(k0, ke + 4, 1) !== 0) begin
      failures++;
      $display("FAIL clean_hit_count: hit=%0d miss=%0d want 1 0", count_bit(k0, ke + 4, 2), count_bit(k0, ke + 4, 1));
    end
  endtask

  task automatic test_cheat_lamp();
    int bad;
    idle($urandom_range(5, FP));
    plan_shot(1, 0, 0, 1, 0, 0, DEB + 7);
    run_to(ke + 5);
    cheat = 0;
    bad = wave_bad(k0, ke + 4);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL cheat_wave: %0d cycles differ, first %0d got %b want %b", bad, first_c, tr[first_c], exp_at(first_c));
    end
    checks++;
    if (count_bit(k0, ke + 4, 2) !== 0 || count_bit(k0, ke + 4, 1) !== 1) begin
      failures++;
      $display("FAIL cheat_count: hit=%0d miss=%0d want 0 1", count_bit(k0, ke + 4, 2), count_bit(k0, ke + 4, 1));
    end
  endtask

  task automatic test_bounce_cooldown();
    int bad;
    clear_plan();
    idle(5);
    k0 = cyc + 1;
    trig_a = k0;
    trig_b = k0 + DEB - 1;
    trig2_a = trig_b + 3;
    trig2_b = trig2_a + DEB / 2;
    run_to(trig2_b + DEB + 5);
    checks++;
    if (count_bit(k0, cyc, 5) !== 0 || count_bit(k0, cyc, 0) !== 0) begin
      failures++;
      $display("FAIL bounce_no_shot: shot=%0d busy=%0d want 0 0", count_bit(k0, cyc, 5), count_bit(k0, cyc, 0));
    end
    idle(3);
    plan_shot(1, 0, 1, 0, 0, 1, DEB + 5);
    run_to(ke + 5);
    bad = wave_bad(k0, ke + 4);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL cooldown_wave: %0d cycles differ, first %0d got %b want %b", bad, first_c, tr[first_c], exp_at(first_c));
    end
    checks++;
    if (tr[ke - 1][0] !== 1'b1 || tr[ke][0] !== 1'b0 || count_bit(k0, ke + 4, 5) !== 1) begin
      failures++;
      $display("FAIL cooldown_busy_end: busy@end-1=%b busy@end=%b shots=%0d want 1 0 1", tr[ke - 1][0], tr[ke][0],
               count_bit(k0, ke + 4, 5));
    end
  endtask

  task automatic test_duck_absent();
    int bad;
    idle($urandom_range(5, FP));
    plan_shot(0, 0, 1, 0, 0, 0, DEB + 3);
    run_to(ke + 5);
    bad = wave_bad(k0, ke + 4);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL duck_absent_wave: %0d cycles differ, first %0d got %b want %b", bad, first_c, tr[first_c], exp_at(first_c));
    end
    checks++;
    if (count_bit(k0, ke + 4, 3) !== 0 || count_bit(k0, ke + 4, 1) !== 1 || count_bit(k0, ke + 4, 2) !== 0) begin
      failures++;
      $display("FAIL duck_absent_count: ftgt=%0d miss=%0d hit=%0d want 0 1 0", count_bit(k0, ke + 4, 3),
               count_bit(k0, ke + 4, 1), count_bit(k0, ke + 4, 2));
    end
  endtask

  task automatic test_disconnect();
    int bad;
    idle($urandom_range(5, FP));
    plan_shot(1, 0, 1, 0, 1, 0, DEB);
    run_to(ke + 5);
    bad = wave_bad(k0, ke + 4);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL disconnect_wave: %0d cycles differ, first %0d got %b want %b", bad, first_c, tr[first_c], exp_at(first_c));
    end
    checks++;
    if (tr[kd - 1][4] !== 1'b1 || tr[kd][4] !== 1'b0 || count_bit(k0, cyc, 2) + count_bit(k0, cyc, 1) !== 0) begin
      failures++;
      $display("FAIL disconnect_abort: fb@kd-1=%b fb@kd=%b results=%0d want 1 0 0", tr[kd - 1][4], tr[kd][4],
               count_bit(k0, cyc, 2) + count_bit(k0, cyc, 1));
    end
    idle(12);
    clear_plan();
    disc_all = 1;
    k0 = cyc + 1;
    trig_a = k0;
    trig_b = k0 + DEB + 10;
    run_to(trig_b + 5);
    disc_all = 0;
    idle(10);
    checks++;
    if (count_bit(k0, cyc, 5) !== 0 || count_bit(k0, cyc, 0) !== 0) begin
      failures++;
      $display("FAIL disconnected_trigger: shot=%0d busy=%0d want 0 0", count_bit(k0, cyc, 5), count_bit(k0, cyc, 0));
    end
  endtask

  task automatic test_random();
    int bad;
    bit dsc;
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(8, FP + 8));
      dsc = ($urandom_range(0, 4) == 0);
      plan_shot(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0, dsc,
                !dsc && 1'($urandom), DEB + $urandom_range(0, 40));
      run_to(ke + 5);
      cheat = 0;
      bad = wave_bad(k0, ke + 4);
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL random%0d_wave: %0d cycles differ, first %0d got %b want %b", i, bad, first_c, tr[first_c], exp_at(first_c));
      end
      checks++;
      if (count_bit(k0, ke + 4, 2) !== ((res && !p_disc) ? 1 : 0) || count_bit(k0, ke + 4, 1) !== ((!res && !p_disc) ? 1 : 0)) begin
        failures++;
        $display("FAIL random%0d_result: hit=%0d miss=%0d want %0d %0d", i, count_bit(k0, ke + 4, 2), count_bit(k0, ke + 4, 1),
                 (res && !p_disc) ? 1 : 0, (!res && !p_disc) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_target();
    test_clean_hit();
    test_cheat_lamp();
    test_bounce_cooldown();
    test_duck_absent();
    test_disconnect();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
